// File: rtl/hydra_pkg.sv
// -----------------------------------------------------------------------------
// hydra_pkg
//   Shared types and constants for the switch port framers.
//   hdr_t      : header word layout {len[8:0], prior[2:0], dest[3:0]}
//   tx_state_t : egress framer states
// -----------------------------------------------------------------------------
package hydra_pkg;

    localparam int DATA_W     = 16;
    localparam int LEN_W      = 9;
    localparam int PAGE_WORDS = 8;

    typedef struct packed {
        logic [8:0] len;     // payload words following the header
        logic [2:0] prior;
        logic [3:0] dest;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        SOP,
        HDR,
        DATA,
        EOP
    } tx_state_t;

endpackage

// File: rtl/tx_page_ctr.sv
// -----------------------------------------------------------------------------
// tx_page_ctr
//   Counts words read out of the current buffer page and issues a one-cycle
//   page release pulse, registered so it lines up with rd_vld of that word.
// Ports
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : restart page counting (start of a packet)
//   i_word       : a word is consumed this cycle
//   i_last       : the consumed word is the last of the packet
//   o_pg_done    : page release pulse
// -----------------------------------------------------------------------------
module tx_page_ctr
    import hydra_pkg::*;
#(
    parameter int WORDS = PAGE_WORDS     // must be a power of two, >= 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_word,
    input  logic i_last,
    output logic o_pg_done
);

    localparam int CNT_W = $clog2(WORDS);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pg_done;
    logic             w_page_end;

    assign w_page_end = (r_cnt == CNT_W'(WORDS - 1));
    assign o_pg_done  = r_pg_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_pg_done <= 1'b0;
        end else begin
            // A full page and a packet end on the same word give one pulse.
            r_pg_done <= i_word && (w_page_end || i_last);
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_word) begin
                r_cnt <= w_page_end ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_tx.sv
// -----------------------------------------------------------------------------
// port_tx
//   Egress framer for one switch output port. Pulls header-first packets from
//   the port queue and re-emits them as rd_sop / rd_vld+rd_data / rd_eop, with
//   a page release pulse every PAGE_WORDS words and on the final word.
// Ports
//   sys_clk, sys_rst : clock, async active-high reset
//   ready            : downstream can take a new packet (looked at in IDLE only)
//   src_vld/src_data : queue head word; src_rdy is the combinational pop
//   rd_sop/rd_vld/rd_data/rd_eop : registered framed output
//   pg_done          : page release, aligned with rd_vld of the page's last word
//   hdr_err          : header dest differs from PORT_ID (packet still forwarded)
//   busy             : high from rd_sop through rd_eop
//   cur_prior/cur_len: fields of the most recent header, held between packets
// -----------------------------------------------------------------------------
module port_tx
    import hydra_pkg::*;
#(
    parameter int DATA_W     = hydra_pkg::DATA_W,
    parameter int LEN_W      = hydra_pkg::LEN_W,
    parameter int PAGE_WORDS = hydra_pkg::PAGE_WORDS,
    parameter int PORT_ID    = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ready,
    input  logic              src_vld,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rdy,
    output logic              rd_sop,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_eop,
    output logic              pg_done,
    output logic              hdr_err,
    output logic              busy,
    output logic [2:0]        cur_prior,
    output logic [LEN_W-1:0]  cur_len
);

    tx_state_t         r_state;
    logic [LEN_W:0]    r_word_cnt;   // words accepted in this packet, header included
    logic              r_rd_sop;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_eop;
    logic              r_hdr_err;
    logic              r_busy;
    logic [2:0]        r_cur_prior;
    logic [LEN_W-1:0]  r_cur_len;

    hdr_t              w_hdr;
    logic              w_accept;
    logic              w_last;
    logic              w_pg_done;

    assign w_hdr    = hdr_t'(src_data);
    assign src_rdy  = (r_state == HDR) || (r_state == DATA);
    assign w_accept = src_vld && src_rdy;

    // The word being accepted in DATA has index r_word_cnt; the last one has
    // index len. A header with len==0 is itself the last word.
    assign w_last = (r_state == HDR) ? (w_hdr.len == '0)
                                     : (r_word_cnt == {1'b0, r_cur_len});

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_word_cnt  <= '0;
            r_rd_sop    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_eop    <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cur_prior <= '0;
            r_cur_len   <= '0;
        end else begin
            // Framing pulses trail the state that produces them by one cycle,
            // so rd_sop lands on the first header slot and rd_eop one cycle
            // after the last rd_vld.
            r_rd_sop  <= (r_state == SOP);
            r_rd_eop  <= (r_state == EOP);
            r_busy    <= (r_state != IDLE);
            r_rd_vld  <= w_accept;
            r_hdr_err <= w_accept && (r_state == HDR) && (w_hdr.dest != 4'(PORT_ID));
            if (w_accept) begin
                r_rd_data <= src_data;
            end

            case (r_state)
                IDLE: begin
                    if (ready && src_vld) begin
                        r_state <= SOP;
                    end
                end
                SOP: begin
                    r_word_cnt <= '0;
                    r_state    <= HDR;
                end
                HDR: begin
                    if (w_accept) begin
                        r_cur_prior <= w_hdr.prior;
                        r_cur_len   <= LEN_W'(w_hdr.len);
                        r_word_cnt  <= (LEN_W + 1)'(1);
                        r_state     <= w_last ? EOP : DATA;
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= EOP;
                        end
                    end
                end
                EOP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    tx_page_ctr #(
        .WORDS (PAGE_WORDS)
    ) u_page_ctr (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_clr     (r_state == SOP),
        .i_word    (w_accept),
        .i_last    (w_last),
        .o_pg_done (w_pg_done)
    );

    assign rd_sop    = r_rd_sop;
    assign rd_vld    = r_rd_vld;
    assign rd_data   = r_rd_data;
    assign rd_eop    = r_rd_eop;
    assign pg_done   = w_pg_done;
    assign hdr_err   = r_hdr_err;
    assign busy      = r_busy;
    assign cur_prior = r_cur_prior;
    assign cur_len   = r_cur_len;

endmodule

// File: tb/tb_port_tx.sv
// -----------------------------------------------------------------------------
// tb_port_tx
//   Drives packets from a word queue into port_tx and compares every cycle
//   against a timeline model: each accepted word schedules its rd_vld one
//   cycle later, a packet start schedules rd_sop two cycles later, and the
//   final word schedules rd_eop two cycles later. Scenario tasks add their
//   own event-count checks.
// -----------------------------------------------------------------------------
module tb_port_tx;

    localparam int PID = 5;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        ready    = 1'b0;
    logic        src_vld  = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy;
    logic [15:0] rd_data;
    logic [2:0]  cur_prior;
    logic [8:0]  cur_len;

    port_tx #(
        .DATA_W (16), .LEN_W (9), .PAGE_WORDS (8), .PORT_ID (PID)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .src_vld   (src_vld),
        .src_data  (src_data),
        .src_rdy   (src_rdy),
        .rd_sop    (rd_sop),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_eop    (rd_eop),
        .pg_done   (pg_done),
        .hdr_err   (hdr_err),
        .busy      (busy),
        .cur_prior (cur_prior),
        .cur_len   (cur_len)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected events for one future cycle.
    typedef struct packed {
        logic        sop;
        logic        vld;
        logic        eop;
        logic        pg;
        logic        err;
        logic        upd;
        logic [2:0]  prior;
        logic [8:0]  len;
        logic [15:0] data;
    } exp_t;

    exp_t        sched[int];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [15:0] feed[$];
    bit          pat[$];
    int          bubble_pct = 0;

    bit          m_in_pkt = 1'b0;
    int          m_open = 0, m_free = 0, m_cnt = 0, m_total = 0;
    int          m_busy_from = -1, m_busy_to = -1;
    logic [2:0]  m_prior = '0;
    logic [8:0]  m_len = '0;

    int          obs_sop, obs_vld, obs_eop, obs_pg, obs_err, last_eop_cyc, last_gap;
    bit          vld_trace[$];
    exp_t        cur_e;
    logic [34:0] exp_vec, act_vec;

    function automatic exp_t get_exp(int c);
        if (sched.exists(c)) return sched[c];
        return '0;
    endfunction

    task automatic model_clear();
        sched.delete();
        m_in_pkt    = 1'b0;
        m_free      = 0;
        m_busy_from = -1;
        m_busy_to   = -1;
        m_prior     = '0;
        m_len       = '0;
    endtask

    task automatic model_step(int c);
        exp_t e;
        if (!m_in_pkt) begin
            if (c >= m_free && ready && src_vld) begin
                m_in_pkt    = 1'b1;
                m_open      = c + 2;
                m_cnt       = 0;
                m_total     = 0;
                e           = get_exp(c + 2);
                e.sop       = 1'b1;
                sched[c + 2] = e;
                m_busy_from = c + 2;
                m_busy_to   = 1 << 30;
            end
        end else if (c >= m_open && src_vld) begin
            e      = get_exp(c + 1);
            e.vld  = 1'b1;
            e.data = src_data;
            if (m_cnt == 0) begin
                m_total = 1 + int'(src_data[15:7]);
                e.upd   = 1'b1;
                e.prior = src_data[6:4];
                e.len   = src_data[15:7];
                e.err   = (src_data[3:0] != 4'(PID));
            end
            e.pg = ((m_cnt % 8) == 7) || (m_cnt == m_total - 1);
            sched[c + 1] = e;
            void'(feed.pop_front());
            m_cnt++;
            if (m_cnt == m_total) begin
                m_in_pkt  = 1'b0;
                m_free    = c + 2;
                m_busy_to = c + 2;
                e         = get_exp(c + 2);
                e.eop     = 1'b1;
                sched[c + 2] = e;
            end
        end
    endtask

    // Input driver: src_vld follows the queue, with bubbles only while the
    // model says words are being taken.
    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
            #1;
            if (m_in_pkt && cyc >= m_open) begin
                if (pat.size() > 0) src_vld = pat.pop_front();
                else                src_vld = ($urandom_range(0, 99) >= bubble_pct);
                if (feed.size() == 0) src_vld = 1'b0;
            end else begin
                src_vld = (feed.size() > 0);
            end
            src_data = (feed.size() > 0) ? feed[0] : 16'h0000;
        end
    end

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge sys_clk) begin
        if (sys_rst) model_clear();
        cur_e = get_exp(cyc);
        sched.delete(cyc);
        if (cur_e.upd) begin
            m_prior = cur_e.prior;
            m_len   = cur_e.len;
        end
        exp_vec = {m_in_pkt && (cyc >= m_open), cur_e.sop, cur_e.vld, cur_e.eop, cur_e.pg,
                   cur_e.err, (cyc >= m_busy_from) && (cyc <= m_busy_to), m_prior, m_len,
                   cur_e.vld ? cur_e.data : 16'h0000};
        act_vec = {src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy, cur_prior, cur_len,
                   rd_vld ? rd_data : 16'h0000};
        n_total++;
        if (act_vec !== exp_vec)
            $display("FAIL cycle %0d outputs {rdy,sop,vld,eop,pg,err,busy,prior,len,data}: got %h expected %h",
                     cyc, act_vec, exp_vec);
        else
            n_pass++;

        if (rd_sop === 1'b1) begin obs_sop++; last_gap = cyc - last_eop_cyc; end
        if (rd_eop === 1'b1) begin obs_eop++; last_eop_cyc = cyc; end
        if (rd_vld === 1'b1) obs_vld++;
        if (pg_done === 1'b1) obs_pg++;
        if (hdr_err === 1'b1) obs_err++;
        if (busy === 1'b1 && rd_sop !== 1'b1 && rd_eop !== 1'b1) vld_trace.push_back(rd_vld);
        if (!sys_rst) model_step(cyc);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        tick(1);
        while ((feed.size() != 0 || m_in_pkt || cyc <= m_free) && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic clear_obs();
        obs_sop = 0; obs_vld = 0; obs_eop = 0; obs_pg = 0; obs_err = 0;
        vld_trace.delete();
    endtask

    task automatic push_pkt(input int len, input int prior, input int dest, input bit seq);
        feed.push_back({9'(len), 3'(prior), 4'(dest)});
        for (int i = 0; i < len; i++) feed.push_back(seq ? 16'(i + 1) : 16'($urandom));
    endtask

    task automatic test_reset();
        tick(2);
        n_total++;
        if ({src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy, cur_prior, cur_len, rd_data} !== '0)
            $display("FAIL reset_state: got %h expected 0",
                     {src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy, cur_prior, cur_len, rd_data});
        else n_pass++;
        sys_rst = 1'b0;
        tick(1);
    endtask

    task automatic test_header_only();
        clear_obs();
        ready = 1'b1;
        push_pkt(0, 1, 3, 1'b1);   // header word 16'h0013
        wait_drain(50);
        n_total++;
        if (obs_sop !== 1 || obs_vld !== 1 || obs_pg !== 1 || obs_eop !== 1 || cur_prior !== 3'd1)
            $display("FAIL header_only sop/vld/pg/eop/prior: got %0d/%0d/%0d/%0d/%0d expected 1/1/1/1/1",
                     obs_sop, obs_vld, obs_pg, obs_eop, cur_prior);
        else n_pass++;
    endtask

    task automatic test_len8();
        clear_obs();
        push_pkt(8, 0, PID, 1'b1);   // header 16'h0405, payload 1..8
        wait_drain(60);
        n_total++;
        if (obs_vld !== 9 || obs_pg !== 2 || obs_eop !== 1 || cur_len !== 9'd8)
            $display("FAIL len8 vld/pg/eop/len: got %0d/%0d/%0d/%0d expected 9/2/1/8",
                     obs_vld, obs_pg, obs_eop, cur_len);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        int tr = 0;
        clear_obs();
        pat = '{1, 0, 1, 0, 1, 1};
        push_pkt(3, 2, PID, 1'b0);
        wait_drain(60);
        foreach (vld_trace[i]) tr = (tr << 1) | int'(vld_trace[i]);
        n_total++;
        if (obs_vld !== 4 || obs_eop !== 1 || vld_trace.size() !== 6 || tr !== 6'b101011)
            $display("FAIL bubbles vld/eop/trace: got %0d/%0d/%b(n=%0d) expected 4/1/101011(n=6)",
                     obs_vld, obs_eop, tr, vld_trace.size());
        else n_pass++;
    endtask

    task automatic test_ready_gating();
        int k = 0;
        clear_obs();
        ready = 1'b0;
        push_pkt(6, 4, PID, 1'b1);
        tick(10);
        n_total++;
        if (obs_sop !== 0 || src_rdy !== 1'b0 || src_vld !== 1'b1)
            $display("FAIL ready_low sop/rdy: got %0d/%0d expected 0/0", obs_sop, src_rdy);
        else n_pass++;
        ready = 1'b1;
        while (!(m_in_pkt && cyc > m_open) && k < 20) begin tick(1); k++; end
        ready = 1'b0;   // dropped mid-packet: the packet must still complete
        wait_drain(60);
        n_total++;
        if (obs_sop !== 1 || obs_vld !== 7 || obs_eop !== 1)
            $display("FAIL ready_drop sop/vld/eop: got %0d/%0d/%0d expected 1/7/1", obs_sop, obs_vld, obs_eop);
        else n_pass++;
        ready = 1'b1;
    endtask

    task automatic test_dest_err();
        clear_obs();
        push_pkt(4, 1, 3, 1'b1);
        push_pkt(2, 7, PID, 1'b1);
        wait_drain(80);
        n_total++;
        if (obs_err !== 1 || obs_vld !== 8 || cur_prior !== 3'd7)
            $display("FAIL dest_err err/vld/prior: got %0d/%0d/%0d expected 1/8/7", obs_err, obs_vld, cur_prior);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        push_pkt(2, 3, PID, 1'b1);
        push_pkt(0, 5, PID, 1'b1);
        wait_drain(60);
        n_total++;
        if (obs_sop !== 2 || obs_eop !== 2 || last_gap !== 2)
            $display("FAIL back_to_back sop/eop/gap: got %0d/%0d/%0d expected 2/2/2", obs_sop, obs_eop, last_gap);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int k = 0;
        clear_obs();
        push_pkt(20, 6, PID, 1'b1);
        while (obs_vld < 3 && k < 40) begin tick(1); k++; end
        sys_rst = 1'b1;
        feed.delete();
        pat.delete();
        #1;
        n_total++;
        if ({src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy, cur_prior, cur_len, rd_data} !== '0)
            $display("FAIL reset_mid_packet outputs: got %h expected 0",
                     {src_rdy, rd_sop, rd_vld, rd_eop, pg_done, hdr_err, busy, cur_prior, cur_len, rd_data});
        else n_pass++;
        tick(2);
        sys_rst = 1'b0;
        clear_obs();
        push_pkt(511, 2, PID, 1'b0);
        wait_drain(700);
        n_total++;
        if (obs_sop !== 1 || obs_vld !== 512 || obs_pg !== 64 || obs_eop !== 1 || cur_len !== 9'd511)
            $display("FAIL len511 sop/vld/pg/eop/len: got %0d/%0d/%0d/%0d/%0d expected 1/512/64/1/511",
                     obs_sop, obs_vld, obs_pg, obs_eop, cur_len);
        else n_pass++;
    endtask

    task automatic test_random();
        int exp_w = 0, exp_pg = 0, exp_err = 0;
        clear_obs();
        bubble_pct = 30;
        for (int p = 0; p < 25; p++) begin
            int len  = $urandom_range(0, 40);
            int dest = ($urandom_range(0, 1) != 0) ? PID : $urandom_range(0, 15);
            push_pkt(len, $urandom_range(0, 7), dest, 1'b0);
            exp_w  += len + 1;
            exp_pg += (len + 8) / 8;
            if (dest != PID) exp_err++;
        end
        for (int k = 0; k < 6000 && (feed.size() != 0 || m_in_pkt); k++) begin
            ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        ready = 1'b1;
        wait_drain(200);
        bubble_pct = 0;
        n_total++;
        if (obs_sop !== 25 || obs_eop !== 25 || obs_vld !== exp_w || obs_pg !== exp_pg || obs_err !== exp_err)
            $display("FAIL random sop/eop/vld/pg/err: got %0d/%0d/%0d/%0d/%0d expected 25/25/%0d/%0d/%0d",
                     obs_sop, obs_eop, obs_vld, obs_pg, obs_err, exp_w, exp_pg, exp_err);
        else n_pass++;
    endtask

    initial begin
        last_eop_cyc = 0;
        last_gap     = 0;
        clear_obs();
        test_reset();
        test_header_only();
        test_len8();
        test_bubbles();
        test_ready_gating();
        test_dest_err();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
